// File: rtl/basic_axis_example_generator_if.sv
// AXI4-Stream bundle between the example generator (master) and its consumer (slave).
interface basic_axis_example_generator_if #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_AXIS_TID_WIDTH   = 1,
  parameter int unsigned C_AXIS_TDEST_WIDTH = 1,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 1
);
  localparam int unsigned LP_KEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  logic                          tvalid;
  logic                          tready;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  logic [LP_KEEP_WIDTH-1:0]      tkeep;
  logic [LP_KEEP_WIDTH-1:0]      tstrb;
  logic                          tlast;
  logic [C_AXIS_TID_WIDTH-1:0]   tid;
  logic [C_AXIS_TDEST_WIDTH-1:0] tdest;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/basic_axis_example_generator.sv
// AXI4-Stream packet generator: on a start pulse emits ctrl_num_pkts packets of
// ctrl_num_beats beats, each lane carrying an incrementing value seeded by ctrl_seed.
module basic_axis_example_generator #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_LEN_WIDTH        = 16,
  parameter int unsigned C_AXIS_TID_WIDTH   = 1,
  parameter int unsigned C_AXIS_TDEST_WIDTH = 1,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 1
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_aresetn,
  input  logic                         ctrl_start,
  input  logic [C_LEN_WIDTH-1:0]       ctrl_num_beats,
  input  logic [C_LEN_WIDTH-1:0]       ctrl_num_pkts,
  input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_seed,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  basic_axis_example_generator_if.master m_axis
);
  localparam int unsigned LP_NUM_LANES  = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int unsigned LP_KEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [C_LEN_WIDTH-1:0]        beats_q, beats_d;
  logic [C_LEN_WIDTH-1:0]        pkts_q, pkts_d;
  logic [C_LEN_WIDTH-1:0]        beat_cnt_q, beat_cnt_d;
  logic [C_LEN_WIDTH-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic [C_ADDER_BIT_WIDTH-1:0]  base_q, base_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          tlast_q, tlast_d;
  logic [C_AXIS_TID_WIDTH-1:0]   tid_q, tid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic xfer_c, last_beat_c, final_beat_c, start_c, start_run_c, start_empty_c;

  // Handshake and run-boundary events for the current cycle
  always_comb begin
    xfer_c        = (state_q == S_RUN) && tvalid_q && m_axis.tready;
    last_beat_c   = (beat_cnt_q == C_LEN_WIDTH'(beats_q - C_LEN_WIDTH'(1)));
    final_beat_c  = xfer_c && last_beat_c &&
                    (pkt_cnt_q == C_LEN_WIDTH'(pkts_q - C_LEN_WIDTH'(1)));
    start_c       = (state_q == S_IDLE) && ctrl_start;
    start_empty_c = start_c && ((ctrl_num_beats == '0) || (ctrl_num_pkts == '0));
    start_run_c   = start_c && !start_empty_c;
  end

  // State register
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic: a non-empty start enters RUN, the final transfer returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_run_c)  state_d = S_RUN;
      S_RUN:   if (final_beat_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values: latch controls on start, advance on each transfer
  always_comb begin
    beats_d    = beats_q;
    pkts_d     = pkts_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    base_d     = base_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tid_d      = tid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tdata_d    = tdata_q;

    if (start_empty_c) begin
      done_d = 1'b1;
    end else if (start_run_c) begin
      beats_d    = ctrl_num_beats;
      pkts_d     = ctrl_num_pkts;
      beat_cnt_d = '0;
      pkt_cnt_d  = '0;
      base_d     = ctrl_seed;
      tvalid_d   = 1'b1;
      busy_d     = 1'b1;
      tlast_d    = (ctrl_num_beats == C_LEN_WIDTH'(1));
      tid_d      = '0;
    end else if (xfer_c) begin
      base_d = C_ADDER_BIT_WIDTH'(base_q + C_ADDER_BIT_WIDTH'(LP_NUM_LANES));
      if (final_beat_c) begin
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
        tlast_d  = 1'b0;
        done_d   = 1'b1;
      end else if (last_beat_c) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = C_LEN_WIDTH'(pkt_cnt_q + C_LEN_WIDTH'(1));
        tid_d      = C_AXIS_TID_WIDTH'(pkt_cnt_d);
        tlast_d    = (beats_q == C_LEN_WIDTH'(1));
      end else begin
        beat_cnt_d = C_LEN_WIDTH'(beat_cnt_q + C_LEN_WIDTH'(1));
        tlast_d    = (beat_cnt_d == C_LEN_WIDTH'(beats_q - C_LEN_WIDTH'(1)));
      end
    end

    // Lane data follows the lane-0 base whenever a new beat is loaded
    if (start_run_c || xfer_c) begin
      for (int i = 0; i < int'(LP_NUM_LANES); i++) begin
        tdata_d[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] =
          C_ADDER_BIT_WIDTH'(base_d + C_ADDER_BIT_WIDTH'(i));
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      beats_q    <= '0;
      pkts_q     <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      base_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      beats_q    <= beats_d;
      pkts_q     <= pkts_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      base_q     <= base_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tid    = tid_q;
  assign m_axis.tkeep  = {LP_KEEP_WIDTH{1'b1}};
  assign m_axis.tstrb  = {LP_KEEP_WIDTH{1'b1}};
  assign m_axis.tdest  = '0;
  assign m_axis.tuser  = '0;
endmodule

// File: tb/tb_basic_axis_example_generator.sv
// Directed bench for the AXI4-Stream example generator.
module tb_basic_axis_example_generator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_beats;
  logic [15:0] num_pkts;
  logic [31:0] seed;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  basic_axis_example_generator_if #(
    .C_AXIS_TDATA_WIDTH(512), .C_AXIS_TID_WIDTH(1),
    .C_AXIS_TDEST_WIDTH(1),   .C_AXIS_TUSER_WIDTH(1)
  ) axis_if ();

  basic_axis_example_generator dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .ctrl_start     (start),
    .ctrl_num_beats (num_beats),
    .ctrl_num_pkts  (num_pkts),
    .ctrl_seed      (seed),
    .ctrl_busy      (busy),
    .ctrl_done      (done),
    .m_axis         (axis_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat k of a run: lane i = s + 16k + i, modulo 2^32
  function automatic logic [511:0] exp_data(input logic [31:0] s, input int k);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = s + 32'(k*16 + i);
    return r;
  endfunction

  // Checks the beat currently on the bus
  task automatic chk_beat(input string tag, input logic [31:0] s, input int k,
                          input logic last, input logic id);
    chk_bit({tag, "_tvalid"}, axis_if.tvalid, 1'b1);
    chk_data({tag, "_tdata"}, axis_if.tdata, exp_data(s, k));
    chk_bit({tag, "_tlast"}, axis_if.tlast, last);
    chk_bit({tag, "_tid"}, axis_if.tid, id);
  endtask

  task automatic launch(input logic [31:0] s, input logic [15:0] b, input logic [15:0] p);
    seed = s; num_beats = b; num_pkts = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int            k;
    int            c;
    logic [3:0]    pat;
    logic [31:0]   lane;
    logic [511:0]  held;
    logic          held_last;

    rst_n = 1'b0; start = 1'b0; num_beats = '0; num_pkts = '0; seed = '0;
    axis_if.tready = 1'b1;
    tick(); tick();

    // Reset state
    chk_bit("rst_tvalid", axis_if.tvalid, 1'b0);
    chk_bit("rst_tlast", axis_if.tlast, 1'b0);
    chk_data("rst_tdata", axis_if.tdata, 512'd0);
    chk_bit("rst_tid", axis_if.tid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_tkeep", &axis_if.tkeep, 1'b1);
    rst_n = 1'b1;
    tick();

    // Run 1: seed 0x100, 3 beats x 2 pkts, always ready
    launch(32'h100, 16'd3, 16'd2);
    chk_bit("r1_busy", busy, 1'b1);
    for (int b = 0; b < 6; b++) begin
      chk_beat($sformatf("r1_b%0d", b), 32'h100, b, (b == 2) || (b == 5), 1'(b / 3));
      chk_bit($sformatf("r1_b%0d_done", b), done, 1'b0);
      if (b == 5) begin
        held = axis_if.tdata;
        lane = held[511:480];
        chk_lane("r1_b5_lane15", lane, 32'h0000015F);
      end
      tick();
    end
    chk_bit("r1_end_tvalid", axis_if.tvalid, 1'b0);
    chk_bit("r1_end_busy", busy, 1'b0);
    chk_bit("r1_end_done", done, 1'b1);
    tick();
    chk_bit("r1_done_pulse", done, 1'b0);

    // Run 2: same run with tready pattern 1,0,0,1
    pat = 4'b1001;
    launch(32'h100, 16'd3, 16'd2);
    k = 0;
    c = 0;
    while (k < 6 && c < 100) begin
      axis_if.tready = pat[c % 4];
      chk_beat($sformatf("r2_c%0d", c), 32'h100, k, (k == 2) || (k == 5), 1'(k / 3));
      held = axis_if.tdata;
      held_last = axis_if.tlast;
      tick();
      if (!axis_if.tready) begin
        chk_data($sformatf("r2_c%0d_hold", c), axis_if.tdata, held);
        chk_bit($sformatf("r2_c%0d_hold_last", c), axis_if.tlast, held_last);
      end else begin
        k++;
      end
      c++;
    end
    chk_bit("r2_completed", k == 6, 1'b1);
    chk_bit("r2_end_tvalid", axis_if.tvalid, 1'b0);
    chk_bit("r2_end_done", done, 1'b1);
    axis_if.tready = 1'b1;
    tick();

    // Lane wrap: seed 0xFFFFFFF8, single beat
    launch(32'hFFFFFFF8, 16'd1, 16'd1);
    chk_beat("wr", 32'hFFFFFFF8, 0, 1'b1, 1'b0);
    held = axis_if.tdata;
    lane = held[31:0];
    chk_lane("wr_lane0", lane, 32'hFFFFFFF8);
    lane = held[287:256];
    chk_lane("wr_lane8", lane, 32'h00000000);
    lane = held[511:480];
    chk_lane("wr_lane15", lane, 32'h00000007);
    tick();
    chk_bit("wr_done", done, 1'b1);
    tick();

    // Empty run: pkts = 0
    launch(32'h55, 16'd4, 16'd0);
    chk_bit("em_tvalid", axis_if.tvalid, 1'b0);
    chk_bit("em_busy", busy, 1'b0);
    chk_bit("em_done", done, 1'b1);
    tick();
    chk_bit("em_tvalid2", axis_if.tvalid, 1'b0);
    chk_bit("em_done2", done, 1'b0);

    // Start ignored mid-run; start in the done cycle accepted
    launch(32'h200, 16'd2, 16'd2);
    for (int b = 0; b < 4; b++) begin
      chk_beat($sformatf("ig_b%0d", b), 32'h200, b, (b % 2) == 1, 1'(b / 2));
      if (b == 1) begin
        seed = 32'h900; num_beats = 16'd1; num_pkts = 16'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk_bit("ig_done", done, 1'b1);
    launch(32'h300, 16'd1, 16'd1);
    chk_beat("bb", 32'h300, 0, 1'b1, 1'b0);
    chk_bit("bb_busy", busy, 1'b1);
    tick();
    chk_bit("bb_done", done, 1'b1);
    tick();

    // Reset mid-run after 2 of 6 beats with tready low
    launch(32'h400, 16'd3, 16'd2);
    tick();
    tick();
    chk_beat("mr_b2", 32'h400, 2, 1'b1, 1'b0);
    axis_if.tready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk_bit("mr_tvalid", axis_if.tvalid, 1'b0);
    chk_bit("mr_done", done, 1'b0);
    chk_bit("mr_busy", busy, 1'b0);
    rst_n = 1'b1;
    axis_if.tready = 1'b1;
    tick();
    chk_bit("mr_done2", done, 1'b0);
    chk_bit("mr_tvalid2", axis_if.tvalid, 1'b0);
    launch(32'h500, 16'd1, 16'd1);
    chk_beat("mr_new", 32'h500, 0, 1'b1, 1'b0);
    tick();
    chk_bit("mr_new_done", done, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
